uart_fifo_component: RTL and testbench
======================================

# uart_fifo_component

Memory-mapped, parametrised UART peripheral for the SoC bus. It is the FIFO-buffered successor to the single-byte UART component and adds:
- independent RX and TX FIFOs of configurable depth;
- a compile-time baud divisor;
- per-source interrupt enables;
- sticky error flags and internal loopback.

It sits on the system bus behind chip select and drives the external serial pins.

## Interface
- CLKS_PER_BIT, 417, system clocks per serial bit; ≥4.
- RX_DEPTH, 16, RX FIFO entries; power of 2, ≥2.
- TX_DEPTH, 16, TX FIFO entries; power of 2, ≥2.
- COMPONENT_ID, 3'b000, value driven on irq_id.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low.
- cs  in  1  chip select, active low.
- rd  in  1  read strobe, active low.
- wr  in  1  write strobe, active low.
- addr  in  3  register select.
- in_data  in  8  write data.
- out_data  out  8  registered read data.
- rx_in  in  1  serial input; asynchronous.
- tx_out  out  1  serial output; idles high.
- irq  out  1  level interrupt, active high.
- irq_id  out  3  constant COMPONENT_ID.

## Operation
**Register map**
- 0 CONTROL (rw):
  - bit0 RX_IRQ_EN;
  - bit1 TX_IRQ_EN;
  - bit2 ERR_IRQ_EN;
  - bit3 LOOPBACK;
  - bit7 FLUSH, write-only and self-clearing; reads 0.
- 1 STATUS (ro):
  - bit0 RX_AVAL (RX FIFO not empty);
  - bit1 RX_FULL;
  - bit2 TX_FULL;
  - bit3 TX_EMPTY;
  - bit4 TX_BUSY (shifter active);
  - bit5 OVERRUN (sticky);
  - bit6 FRAME_ERR (sticky).
- 2 DATA: a write pushes the TX FIFO; a read pops the RX FIFO.
- 3 RX_COUNT (ro).
- 4 TX_COUNT (ro).
- 5–7: read 0, writes ignored.

**Bus access**
- An access fires only on the first cycle of (cs|wr)==0 or (cs|rd)==0. Strobes are edge-detected against the previous cycle, so a held strobe acts once.
- Read: out_data is loaded at the access cycle and holds until the next read.
- Reading STATUS clears OVERRUN and FRAME_ERR. The value returned shows them set.
- DATA read with RX FIFO empty: returns 0, no pop, no flag.
- DATA write with TX FIFO full: data dropped, no flag.
- FLUSH:
  - empties both FIFOs and clears the sticky flags;
  - a frame already shifting completes;
  - does not set any CONTROL bit.

**TX engine** (TxIdle → TxStart → TxData → TxStop → TxIdle)
- In TxIdle with the FIFO not empty, pop the head in the same cycle.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
- After TxStop, the engine returns to TxIdle and can pop the next byte on the following cycle, giving back-to-back frames.

**RX engine** (RxIdle → RxStart → RxData → RxStop → RxIdle)
- rx_in passes through a 2-flop synchronizer. A falling edge enters RxStart.
- At CLKS_PER_BIT/2 the line is re-sampled. If it reads 1, this is a false start: return to RxIdle.
- Data bits are sampled at bit centres. The stop bit is sampled at its centre:
  - 0: set FRAME_ERR, discard the byte;
  - 1: push the byte. If the RX FIFO is full, drop the byte and set OVERRUN.
- In LOOPBACK the RX input is the internal TX serial stream and tx_out is forced to 1.

**Interrupt**
- irq is registered and equals (RX_IRQ_EN & RX_AVAL) | (TX_IRQ_EN & TX_EMPTY & ~TX_BUSY) | (ERR_IRQ_EN & (OVERRUN|FRAME_ERR)).

## Timing
**Reset values** (while reset=0, sampled on clock):
- tx_out=1, out_data=0, irq=0, irq_id=COMPONENT_ID;
- CONTROL=0, both FIFOs empty, flags 0, both engines idle.

Reset mid-frame aborts the frame immediately, so tx_out=1 on the next edge.

**Latencies**
- DATA write to tx_out falling (start bit), shifter idle: 2 cycles (push cycle, pop cycle, then start bit).
- Stop-bit centre sample to RX_AVAL visible in STATUS: 1 cycle.
- irq follows its sources by 1 cycle.

**FIFO rules**
- Push and pop in the same cycle are both honoured; count is unchanged.
- With the FIFO full, a simultaneous pop and push is allowed.
- Pointers wrap modulo depth. Count is $clog2(DEPTH)+1 bits and is zero-extended into 8 bits.

**Simultaneous events**
- FLUSH has priority over a push or pop in the same cycle.
- If a sticky flag is set in the same cycle as a STATUS read clears it, the flag remains set.

## Structure
Package uart_pkg holds:
- register address constants;
- CONTROL and STATUS bit indices;
- TX and RX state enums.

Sub-module uart_sync_fifo: parameters WIDTH and DEPTH; ports push, pop, data in/out, full, empty, count, flush. It is instantiated once for RX and once for TX. The serial engines and the register file stay in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4 and depths of 4.
- Reset: hold reset=0 for 3 cycles → tx_out=1, irq=0, STATUS reads 8'h08.
- TX: write 8'hA5 to DATA → start bit 2 cycles later, then 1,0,1,0,0,1,0,1, then stop; each bit lasts 4 cycles; TX_BUSY clears after the stop bit.
- TX burst and overflow: write 5 bytes back-to-back while the shifter is busy → TX_COUNT=4, 5th byte dropped; all frames contiguous with no idle gap.
- RX and interrupt: CONTROL=8'h01, drive frame 8'h3C on rx_in → irq=1; DATA read returns 8'h3C; irq drops 1 cycle after the pop.
- Overrun and frame error:
  - 5 RX frames with no reads → RX_COUNT=4, STATUS bit5=1;
  - a frame with stop=0 → bit6=1;
  - a STATUS read clears both.
- Loopback and flush:
  - CONTROL=8'h08, write 8'h5A → DATA read returns 8'h5A, tx_out stays 1;
  - then write CONTROL=8'h80 with both FIFOs populated → both counts 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit indices and engine states for uart_fifo_component
package uart_pkg;

    localparam logic [2:0] ADDR_CONTROL  = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_DATA     = 3'd2;
    localparam logic [2:0] ADDR_RX_COUNT = 3'd3;
    localparam logic [2:0] ADDR_TX_COUNT = 3'd4;

    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TX_IRQ_EN  = 1;
    localparam int CTRL_ERR_IRQ_EN = 2;
    localparam int CTRL_LOOPBACK   = 3;
    localparam int CTRL_FLUSH      = 7;

    localparam int STAT_RX_AVAL   = 0;
    localparam int STAT_RX_FULL   = 1;
    localparam int STAT_TX_FULL   = 2;
    localparam int STAT_TX_EMPTY  = 3;
    localparam int STAT_TX_BUSY   = 4;
    localparam int STAT_OVERRUN   = 5;
    localparam int STAT_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with flush, show-ahead head and occupancy count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a push when the same cycle pops a slot free.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/uart_fifo_component.sv
// rtl/uart_fifo_component.sv - bus-mapped UART with RX/TX FIFOs, sticky errors, loopback and irq
module uart_fifo_component
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 417,
    parameter int         RX_DEPTH     = 16,
    parameter int         TX_DEPTH     = 16,
    parameter logic [2:0] COMPONENT_ID = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    input  logic       rx_in,
    output logic       tx_out,
    output logic       irq,
    output logic [2:0] irq_id
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    // The idle cycle that pops the next byte supplies the last stop-bit clock.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

    logic wr_act, rd_act, wr_act_q, rd_act_q, wr_fire, rd_fire;
    logic [3:0] ctrl;
    logic flush, status_rd, tx_push, rx_pop;
    logic overrun, frame_err, overrun_set, frame_set;
    logic [7:0] rd_data;
    logic unused_in_data;

    logic rx_full, rx_empty, tx_full, tx_empty, rx_push, tx_pop, tx_busy;
    logic [7:0] rx_head, tx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [$clog2(TX_DEPTH):0] tx_count;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;
    logic             tx_serial, tx_serial_nxt;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;
    logic             rx_src, rx_meta, rx_sync, rx_sync_q;

    assign unused_in_data = ^in_data[6:4];

    assign wr_act  = ~(cs | wr);
    assign rd_act  = ~(cs | rd);
    assign wr_fire = wr_act & ~wr_act_q;
    assign rd_fire = rd_act & ~rd_act_q;

    assign flush     = wr_fire & (addr == ADDR_CONTROL) & in_data[CTRL_FLUSH];
    assign tx_push   = wr_fire & (addr == ADDR_DATA);
    assign rx_pop    = rd_fire & (addr == ADDR_DATA);
    assign status_rd = rd_fire & (addr == ADDR_STATUS);
    assign tx_busy   = (tx_state != TX_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_act_q <= 1'b0;
            rd_act_q <= 1'b0;
            ctrl     <= '0;
        end else begin
            wr_act_q <= wr_act;
            rd_act_q <= rd_act;
            if (wr_fire && addr == ADDR_CONTROL)
                ctrl <= in_data[3:0];
        end
    end

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (tx_push),
        .push_data (in_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_CONTROL:  rd_data = {4'b0000, ctrl};
            ADDR_STATUS:   rd_data = {1'b0, frame_err, overrun, tx_busy,
                                      tx_empty, tx_full, rx_full, ~rx_empty};
            ADDR_DATA:     rd_data = rx_empty ? 8'h00 : rx_head;
            ADDR_RX_COUNT: rd_data = 8'(rx_count);
            ADDR_TX_COUNT: rd_data = 8'(tx_count);
            default:       rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            out_data <= 8'h00;
        else if (rd_fire)
            out_data <= rd_data;
    end

    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_bit_nxt    = tx_bit;
        tx_shift_nxt  = tx_shift;
        tx_serial_nxt = tx_serial;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !flush) begin
                    tx_pop        = 1'b1;
                    tx_shift_nxt  = tx_head;
                    tx_serial_nxt = 1'b0;
                    tx_cnt_nxt    = '0;
                    tx_state_nxt  = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt    = '0;
                    tx_bit_nxt    = 3'd0;
                    tx_serial_nxt = tx_shift[0];
                    tx_state_nxt  = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
                        tx_serial_nxt = 1'b1;
                        tx_state_nxt  = TX_STOP;
                    end else begin
                        tx_shift_nxt  = {1'b0, tx_shift[7:1]};
                        tx_serial_nxt = tx_shift[1];
                        tx_bit_nxt    = tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == STOP_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_serial <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_shift  <= tx_shift_nxt;
            tx_serial <= tx_serial_nxt;
        end
    end

    assign tx_out = ctrl[CTRL_LOOPBACK] | tx_serial;
    assign rx_src = ctrl[CTRL_LOOPBACK] ? tx_serial : rx_in;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta   <= rx_src;
            rx_sync   <= rx_meta;
            rx_sync_q <= rx_sync;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_push      = 1'b0;
        frame_set    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_sync_q && !rx_sync) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = 3'd0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7)
                        rx_state_nxt = RX_STOP;
                    else
                        rx_bit_nxt = rx_bit + 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    rx_push      = rx_sync;
                    frame_set    = ~rx_sync;
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    assign overrun_set = rx_push & rx_full & ~rx_pop;

    // A set in the same cycle as a STATUS read wins so no event is lost.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set)
                overrun <= 1'b1;
            else if (status_rd)
                overrun <= 1'b0;
            if (frame_set)
                frame_err <= 1'b1;
            else if (status_rd)
                frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            irq <= 1'b0;
        else
            irq <= (ctrl[CTRL_RX_IRQ_EN]  & ~rx_empty)
                 | (ctrl[CTRL_TX_IRQ_EN]  & tx_empty & ~tx_busy)
                 | (ctrl[CTRL_ERR_IRQ_EN] & (overrun | frame_err));
    end

    assign irq_id = COMPONENT_ID;

endmodule

// File: tb/tb_uart_fifo_component.sv
// tb/tb_uart_fifo_component.sv - directed self-checking bench for uart_fifo_component
module tb_uart_fifo_component;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b1;
    logic       rd = 1'b1;
    logic       wr = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] out_data;
    logic       rx_in = 1'b1;
    logic       tx_out;
    logic       irq;
    logic [2:0] irq_id;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    uart_fifo_component #(
        .CLKS_PER_BIT (4),
        .RX_DEPTH     (4),
        .TX_DEPTH     (4),
        .COMPONENT_ID (3'b101)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .in_data  (in_data),
        .out_data (out_data),
        .rx_in    (rx_in),
        .tx_out   (tx_out),
        .irq      (irq),
        .irq_id   (irq_id)
    );

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clock);
        cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
        @(negedge clock);
        cs = 1'b1; wr = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clock);
        cs = 1'b0; rd = 1'b0; addr = a;
        @(negedge clock);
        d = out_data;
        cs = 1'b1; rd = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clock);
        rx_in = 1'b0;
        repeat (4) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (4) @(negedge clock);
        end
        rx_in = stop;
        repeat (4) @(negedge clock);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        vectors++; if (tx_out !== 1'b1) begin miscompares++; $display("FAIL reset_tx_out got %b exp 1", tx_out); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq); end
        vectors++; if (irq_id !== 3'b101) begin miscompares++; $display("FAIL reset_irq_id got %b exp 101", irq_id); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        reset = 1'b1;
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL reset_status got %h exp 08", d); end
    endtask

    task automatic test_regs();
        logic [7:0] d;
        bus_write(3'd0, 8'h0F);
        bus_read(3'd0, d);
        vectors++; if (d !== 8'h0F) begin miscompares++; $display("FAIL ctrl_readback got %h exp 0F", d); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL tx_idle_irq got %b exp 1", irq); end
        bus_write(3'd5, 8'hFF);
        bus_read(3'd5, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reg5_read got %h exp 00", d); end
        bus_write(3'd0, 8'h00);
        @(negedge clock);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_disabled got %b exp 0", irq); end
    endtask

    task automatic test_tx();
        logic [7:0] d;
        bus_write(3'd2, 8'hA5);
        vectors++; if (tx_out !== 1'b1) begin miscompares++; $display("FAIL tx_pre_start got %b exp 1", tx_out); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            vectors++;
            if (tx_out !== frame_bit(8'hA5, c / 4)) begin
                miscompares++;
                $display("FAIL tx_frame cycle %0d got %b exp %b", c, tx_out, frame_bit(8'hA5, c / 4));
            end
        end
        repeat (4) @(negedge clock);
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL tx_done_status got %h exp 08", d); end
    endtask

    task automatic test_tx_burst();
        logic [7:0] d;
        logic [7:0] bytes [5];
        bytes = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};
        fork
            begin
                bus_write(3'd2, 8'hF0);
                bus_write(3'd2, 8'h11);
                bus_write(3'd2, 8'h22);
                bus_write(3'd2, 8'h33);
                bus_write(3'd2, 8'h44);
                bus_write(3'd2, 8'h55);
                bus_read(3'd4, d);
                vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL burst_tx_count got %h exp 04", d); end
                bus_read(3'd1, d);
                vectors++; if (d !== 8'h14) begin miscompares++; $display("FAIL burst_status got %h exp 14", d); end
            end
            begin
                repeat (3) @(negedge clock);
                for (int c = 0; c < 200; c++) begin
                    if (c > 0) @(negedge clock);
                    vectors++;
                    if (tx_out !== frame_bit(bytes[c / 40], (c % 40) / 4)) begin
                        miscompares++;
                        $display("FAIL burst_stream cycle %0d got %b exp %b", c, tx_out,
                                 frame_bit(bytes[c / 40], (c % 40) / 4));
                    end
                end
            end
        join
        repeat (4) @(negedge clock);
        bus_read(3'd4, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL burst_drained got %h exp 00", d); end
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL burst_idle_status got %h exp 08", d); end
    endtask

    task automatic test_rx_irq();
        logic [7:0] d;
        bus_write(3'd0, 8'h01);
        send_rx(8'h3C, 1'b1);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rx_irq_early got %b exp 0", irq); end
        repeat (2) @(negedge clock);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL rx_irq_set got %b exp 1", irq); end
        bus_read(3'd2, d);
        vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL rx_data got %h exp 3C", d); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL rx_irq_pop_cycle got %b exp 1", irq); end
        @(negedge clock);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rx_irq_drop got %b exp 0", irq); end
        bus_write(3'd0, 8'h00);
    endtask

    task automatic test_overrun_frame();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) send_rx(8'h11 + 8'(i), 1'b1);
        repeat (2) @(negedge clock);
        bus_read(3'd3, d);
        vectors++; if (d !== 8'h04) begin miscompares++; $display("FAIL ovr_rx_count got %h exp 04", d); end
        send_rx(8'h77, 1'b0);
        repeat (2) @(negedge clock);
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h6B) begin miscompares++; $display("FAIL ovr_status_set got %h exp 6B", d); end
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h0B) begin miscompares++; $display("FAIL ovr_status_clr got %h exp 0B", d); end
        @(negedge clock);
        cs = 1'b0; rd = 1'b0; addr = 3'd2;
        repeat (3) @(negedge clock);
        d = out_data;
        cs = 1'b1; rd = 1'b1;
        vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL held_read_data got %h exp 11", d); end
        bus_read(3'd3, d);
        vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL held_read_count got %h exp 03", d); end
        for (int i = 0; i < 3; i++) begin
            bus_read(3'd2, d);
            vectors++;
            if (d !== 8'h12 + 8'(i)) begin
                miscompares++;
                $display("FAIL ovr_drain %0d got %h exp %h", i, d, 8'h12 + 8'(i));
            end
        end
        bus_read(3'd2, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL empty_data_read got %h exp 00", d); end
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL ovr_final_status got %h exp 08", d); end
    endtask

    task automatic test_loopback_flush();
        logic [7:0] d;
        bus_write(3'd0, 8'h08);
        bus_write(3'd2, 8'h5A);
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            vectors++;
            if (tx_out !== 1'b1) begin miscompares++; $display("FAIL lb_tx_out cycle %0d got %b exp 1", c, tx_out); end
        end
        bus_read(3'd2, d);
        vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL lb_data got %h exp 5A", d); end
        bus_write(3'd2, 8'h61);
        bus_write(3'd2, 8'h62);
        bus_write(3'd2, 8'h63);
        repeat (50) @(negedge clock);
        bus_read(3'd3, d);
        vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL pre_flush_rx_count got %h exp 01", d); end
        bus_read(3'd4, d);
        vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL pre_flush_tx_count got %h exp 01", d); end
        bus_write(3'd0, 8'h80);
        bus_read(3'd3, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL flush_rx_count got %h exp 00", d); end
        bus_read(3'd4, d);
        vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL flush_tx_count got %h exp 00", d); end
        bus_read(3'd1, d);
        vectors++; if (d !== 8'h18) begin miscompares++; $display("FAIL flush_status got %h exp 18", d); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_regs();
        test_tx();
        test_tx_burst();
        test_rx_irq();
        test_overrun_frame();
        test_loopback_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
